// File: rtl/ax_btb_assoc_pkg.sv
// ax_btb_assoc_pkg: default geometry and shared helpers for the approximate-branch BTB.
package ax_btb_assoc_pkg;
  localparam int AXBTB_PC_WIDTH    = 32;
  localparam int AXBTB_ENTRY_NUM   = 64;
  localparam int AXBTB_WAYS        = 2;
  localparam int AXBTB_READ_NUM    = 2;
  localparam int AXBTB_WRITE_NUM   = 2;
  localparam int AXBTB_QUEUE_DEPTH = 4;
  localparam int AXBTB_INSN_BYTES  = 4;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/ax_btb_write_queue.sv
// ax_btb_write_queue: multi-push, single-pop FIFO of pending BTB writes with occupancy and push capacity.
module ax_btb_write_queue #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  parameter int NPUSH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       pop,
  input  logic [NPUSH-1:0]           push_en,
  input  logic [NPUSH*W-1:0]         push_data,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     cap
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign head  = mem_q[rp_q];
  assign count = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign cap   = CW'(DEPTH) - cnt_q + CW'(pop);
  // A pop frees its slot for a same-cycle push; the head is read before the edge.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q - CW'(pop);
    for (int j = 0; j < NPUSH; j++)
      if (push_en[j]) begin
        mem_d[wp_d] = push_data[j*W +: W];
        wp_d        = wp_d + PW'(1);
        cnt_d       = cnt_d + CW'(1);
      end
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ax_btb_assoc.sv
// ax_btb_assoc: set-associative BTB for approximate branches; one commit per cycle, surplus writes queued.
module ax_btb_assoc
  import ax_btb_assoc_pkg::*;
#(
  parameter int PC_WIDTH    = AXBTB_PC_WIDTH,
  parameter int ENTRY_NUM   = AXBTB_ENTRY_NUM,
  parameter int WAYS        = AXBTB_WAYS,
  parameter int READ_NUM    = AXBTB_READ_NUM,
  parameter int WRITE_NUM   = AXBTB_WRITE_NUM,
  parameter int QUEUE_DEPTH = AXBTB_QUEUE_DEPTH,
  parameter int INSN_BYTES  = AXBTB_INSN_BYTES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PC_WIDTH-1:0]           rd_pc,
  output logic [READ_NUM-1:0]           rd_hit,
  output logic [READ_NUM*PC_WIDTH-1:0]  rd_target,
  output logic [READ_NUM-1:0]           rd_is_cond,
  input  logic [WRITE_NUM-1:0]          wr_valid,
  input  logic [WRITE_NUM*PC_WIDTH-1:0] wr_br_pc,
  input  logic [WRITE_NUM*PC_WIDTH-1:0] wr_target,
  input  logic [WRITE_NUM-1:0]          wr_is_cond,
  input  logic                          flush,
  output logic [$clog2(QUEUE_DEPTH):0]  q_count,
  output logic                          q_full,
  output logic [15:0]                   drop_cnt
);
  localparam int SETS = ENTRY_NUM / WAYS;
  localparam int IW   = $clog2(SETS);
  localparam int OFF  = $clog2(INSN_BYTES);
  localparam int TW   = PC_WIDTH - IW - OFF;
  localparam int WW   = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int QW   = $clog2(QUEUE_DEPTH) + 1;
  typedef logic [IW-1:0] AXBTB_SetPath;
  typedef logic [TW-1:0] AXBTB_TagPath;
  typedef struct packed {
    logic                valid;
    AXBTB_TagPath        tag;
    logic [PC_WIDTH-1:0] target;
    logic                isCond;
  } AXBTB_AssocEntry;
  typedef struct packed {
    logic [PC_WIDTH-1:0] brPC;
    logic [PC_WIDTH-1:0] target;
    logic                isCond;
  } AXBTB_WriteReq;
  localparam int RW = $bits(AXBTB_WriteReq);
  function automatic AXBTB_SetPath set_of(input logic [PC_WIDTH-1:0] pc);
    return pc[OFF +: IW];
  endfunction
  function automatic AXBTB_TagPath tag_of(input logic [PC_WIDTH-1:0] pc);
    return pc[PC_WIDTH-1 -: TW];
  endfunction
  AXBTB_AssocEntry ent_q [SETS][WAYS];
  AXBTB_AssocEntry ent_d [SETS][WAYS];
  logic [WW-1:0] vic_q [SETS];
  logic [WW-1:0] vic_d [SETS];
  logic [PC_WIDTH-1:0] sa [READ_NUM];
  logic [READ_NUM-1:0] hit_q, hit_d, cond_q, cond_d;
  logic [READ_NUM*PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [15:0] drop_q, drops;
  AXBTB_WriteReq [WRITE_NUM-1:0] lane;
  logic [RW-1:0] head_bits;
  AXBTB_WriteReq head, cmt;
  logic [WRITE_NUM-1:0] push_en;
  logic [QW-1:0] cap;
  logic pop, cmt_v, found, evict;
  logic [WW-1:0] way;
  AXBTB_SetPath cs;
  AXBTB_TagPath ct;
  int k;
  for (genvar i = 0; i < READ_NUM; i++) begin : g_slot
    assign sa[i] = rd_pc + PC_WIDTH'(i * INSN_BYTES);
  end
  for (genvar j = 0; j < WRITE_NUM; j++) begin : g_lane
    assign lane[j] = '{brPC: wr_br_pc[j*PC_WIDTH +: PC_WIDTH], target: wr_target[j*PC_WIDTH +: PC_WIDTH],
                       isCond: wr_is_cond[j]};
  end
  assign head = head_bits;
  assign pop  = (q_count != '0) && !flush;
  ax_btb_write_queue #(.W(RW), .DEPTH(QUEUE_DEPTH), .NPUSH(WRITE_NUM)) u_wq (
    .clk(clk), .rst(rst), .clr(flush), .pop(pop), .push_en(push_en), .push_data(lane),
    .head(head_bits), .count(q_count), .full(q_full), .cap(cap)
  );
  // Reads look at the pre-commit array, so a same-edge write stays invisible.
  always_comb begin
    hit_d  = '0;
    cond_d = '0;
    tgt_d  = '0;
    for (int i = 0; i < READ_NUM; i++)
      for (int w = 0; w < WAYS; w++)
        if (!flush && ent_q[set_of(sa[i])][w].valid && ent_q[set_of(sa[i])][w].tag == tag_of(sa[i])) begin
          hit_d[i]                      = 1'b1;
          cond_d[i]                     = ent_q[set_of(sa[i])][w].isCond;
          tgt_d[i*PC_WIDTH +: PC_WIDTH] = ent_q[set_of(sa[i])][w].target;
        end
  end
  always_comb begin
    cmt     = head;
    cmt_v   = q_count != '0;
    push_en = '0;
    drops   = '0;
    k       = 0;
    for (int j = 0; j < WRITE_NUM; j++)
      if (wr_valid[j] && !flush) begin
        if (!cmt_v) begin
          cmt_v = 1'b1;
          cmt   = lane[j];
        end else if (k < int'(cap)) begin
          push_en[j] = 1'b1;
          k          = k + 1;
        end else drops = drops + 16'd1;
      end
  end
  // Way priority: tag hit, then lowest invalid, then the round-robin victim.
  always_comb begin
    cs    = set_of(cmt.brPC);
    ct    = tag_of(cmt.brPC);
    found = 1'b0;
    way   = '0;
    evict = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!found && ent_q[cs][w].valid && ent_q[cs][w].tag == ct) begin
        found = 1'b1;
        way   = WW'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (!found && !ent_q[cs][w].valid) begin
        found = 1'b1;
        way   = WW'(w);
      end
    if (!found) begin
      way   = vic_q[cs];
      evict = 1'b1;
    end
    ent_d = ent_q;
    vic_d = vic_q;
    if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        vic_d[s] = '0;
        for (int w = 0; w < WAYS; w++) ent_d[s][w].valid = 1'b0;
      end
    end else if (cmt_v) begin
      ent_d[cs][way] = '{valid: 1'b1, tag: ct, target: cmt.target, isCond: cmt.isCond};
      if (evict) vic_d[cs] = WW'((int'(vic_q[cs]) + 1) % WAYS);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        vic_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) ent_q[s][w] <= '0;
      end
      hit_q  <= '0;
      cond_q <= '0;
      tgt_q  <= '0;
      drop_q <= '0;
    end else begin
      ent_q  <= ent_d;
      vic_q  <= vic_d;
      hit_q  <= hit_d;
      cond_q <= cond_d;
      tgt_q  <= tgt_d;
      drop_q <= sat_add16(drop_q, drops);
    end
  assign rd_hit     = hit_q;
  assign rd_is_cond = cond_q;
  assign rd_target  = tgt_q;
  assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_ax_btb_assoc.sv
// tb_ax_btb_assoc: directed bench with a set/queue reference model and literal anchor checks.
module tb_ax_btb_assoc;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] rd_pc = '0;
  logic [1:0]  rd_hit, rd_is_cond;
  logic [63:0] rd_target;
  logic [1:0]  wr_valid = '0, wr_is_cond = '0;
  logic [63:0] wr_br_pc = '0, wr_target = '0;
  logic        flush = 1'b0;
  logic [2:0]  q_count;
  logic        q_full;
  logic [15:0] drop_cnt;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  ax_btb_assoc dut (
    .clk(clk), .rst(rst), .rd_pc(rd_pc), .rd_hit(rd_hit), .rd_target(rd_target), .rd_is_cond(rd_is_cond),
    .wr_valid(wr_valid), .wr_br_pc(wr_br_pc), .wr_target(wr_target), .wr_is_cond(wr_is_cond),
    .flush(flush), .q_count(q_count), .q_full(q_full), .drop_cnt(drop_cnt)
  );
  typedef struct {logic [31:0] pc; logic [31:0] tgt; logic cond;} req_t;
  req_t        mq[$];
  bit          mv [32][2];
  logic [24:0] mt [32][2];
  logic [31:0] mg [32][2];
  bit          mc [32][2];
  int          mvic [32];
  int          mdrop;
  logic [1:0]  e_hit, e_cond;
  logic [63:0] e_tgt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int s = 0; s < 32; s++) begin
      mvic[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 0; mt[s][w] = '0; mg[s][w] = '0; mc[s][w] = 0;
      end
    end
    mq.delete();
    mdrop = 0;
    e_hit = '0; e_cond = '0; e_tgt = '0;
  endfunction
  // Applies the current inputs to the model as one clock edge would.
  function automatic void model_edge();
    req_t c, r;
    bit have;
    logic [31:0] a;
    int s, way;
    e_hit = '0; e_cond = '0; e_tgt = '0;
    for (int i = 0; i < 2; i++) begin
      a = rd_pc + 32'(4 * i);
      s = int'(a[6:2]);
      for (int w = 0; w < 2; w++)
        if (!flush && mv[s][w] && mt[s][w] == a[31:7]) begin
          e_hit[i] = 1'b1; e_cond[i] = mc[s][w]; e_tgt[i*32 +: 32] = mg[s][w];
        end
    end
    if (flush) begin
      for (int t = 0; t < 32; t++) begin
        mvic[t] = 0; mv[t][0] = 0; mv[t][1] = 0;
      end
      mq.delete();
      return;
    end
    have = 0;
    if (mq.size() > 0) begin
      c = mq.pop_front();
      have = 1;
    end
    for (int j = 0; j < 2; j++)
      if (wr_valid[j]) begin
        r.pc = wr_br_pc[j*32 +: 32]; r.tgt = wr_target[j*32 +: 32]; r.cond = wr_is_cond[j];
        if (!have) begin c = r; have = 1; end
        else if (mq.size() < 4) mq.push_back(r);
        else if (mdrop < 65535) mdrop++;
      end
    if (!have) return;
    s = int'(c.pc[6:2]);
    way = -1;
    for (int w = 0; w < 2; w++) if (way < 0 && mv[s][w] && mt[s][w] == c.pc[31:7]) way = w;
    for (int w = 0; w < 2; w++) if (way < 0 && !mv[s][w]) way = w;
    if (way < 0) begin
      way = mvic[s];
      mvic[s] = (mvic[s] + 1) % 2;
    end
    mv[s][way] = 1; mt[s][way] = c.pc[31:7]; mg[s][way] = c.tgt; mc[s][way] = c.cond;
  endfunction
  task automatic step(input logic [31:0] pc, input logic [1:0] v, input logic [31:0] p0, input logic [31:0] t0,
                      input logic [31:0] p1, input logic [31:0] t1, input logic [1:0] cnd, input logic fl);
    rd_pc = pc; wr_valid = v; wr_br_pc = {p1, p0}; wr_target = {t1, t0}; wr_is_cond = cnd; flush = fl;
    model_edge();
    @(posedge clk);
    #1;
    chk("rd_hit", rd_hit, e_hit);
    chk("rd_target", rd_target, e_tgt);
    chk("rd_is_cond", rd_is_cond, e_cond);
    chk("q_count", q_count, mq.size());
    chk("q_full", q_full, mq.size() == 4);
    chk("drop_cnt", drop_cnt, mdrop);
  endtask
  task automatic rd(input logic [31:0] pc);
    step(pc, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask
  task automatic wr1(input logic [31:0] p, input logic [31:0] t);
    step(32'h0, 2'b01, p, t, 0, 0, 2'b00, 1'b0);
  endtask
  int qe[6] = '{1, 2, 3, 4, 4, 4};
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hit", rd_hit, 0);
    chk("reset_qcount", q_count, 0);
    chk("reset_drop", drop_cnt, 0);
    rst = 1'b0;
    rd(32'h1000);
    chk("t1_hit_lit", rd_hit, 2'b00);
    chk("t1_target_lit", rd_target, 64'h0);
    step(32'h0, 2'b01, 32'h1000, 32'h2000, 0, 0, 2'b01, 1'b0);
    rd(32'h1000);
    chk("t2_hit_lit", rd_hit, 2'b01);
    chk("t2_target_lit", rd_target[31:0], 32'h2000);
    chk("t2_cond_lit", rd_is_cond, 2'b01);
    step(32'h1004, 2'b11, 32'h1004, 32'h3000, 32'h1008, 32'h4000, 2'b00, 1'b0);
    chk("t3_same_edge_lit", rd_hit, 2'b00);
    chk("t3_qcount1_lit", q_count, 1);
    rd(32'h1004);
    chk("t3_qcount0_lit", q_count, 0);
    chk("t3_partial_lit", rd_hit, 2'b01);
    rd(32'h1004);
    chk("t3_both_lit", rd_hit, 2'b11);
    chk("t3_target_lit", rd_target, {32'h4000, 32'h3000});
    wr1(32'h1080, 32'h6000);
    wr1(32'h1100, 32'h7000);
    rd(32'h1080);
    chk("t4_1080_lit", rd_hit, 2'b01);
    rd(32'h1000);
    chk("t4_1000_evicted_lit", rd_hit, 2'b10);
    wr1(32'h1080, 32'h5000);
    rd(32'h1100);
    chk("t4_1100_kept_lit", rd_target[31:0], 32'h7000);
    rd(32'h1080);
    chk("t4_inplace_lit", rd_target[31:0], 32'h5000);
    for (int c = 0; c < 6; c++) begin
      step(32'h0, 2'b11, 32'h3000 + 32'(8 * c), 32'h9000 + 32'(8 * c),
           32'h3004 + 32'(8 * c), 32'h9004 + 32'(8 * c), 2'b10, 1'b0);
      chk("t5_qcount_lit", q_count, qe[c]);
      chk("t5_qfull_lit", q_full, c >= 3);
    end
    chk("t5_drop_lit", drop_cnt, 2);
    repeat (4) rd(32'h0);
    chk("t5_drained_lit", q_count, 0);
    for (int c = 0; c < 6; c++) begin
      rd(32'h3000 + 32'(8 * c));
      chk("t5_hits_lit", rd_hit, c >= 4 ? 2'b01 : 2'b11);
    end
    for (int c = 0; c < 3; c++)
      step(32'h0, 2'b11, 32'h3100 + 32'(8 * c), 32'h1, 32'h3104 + 32'(8 * c), 32'h2, 2'b00, 1'b0);
    chk("t6_pre_qcount_lit", q_count, 3);
    step(32'h3000, 2'b11, 32'h3400, 32'h1, 32'h3404, 32'h2, 2'b00, 1'b1);
    chk("t6_flush_qcount_lit", q_count, 0);
    chk("t6_flush_hit_lit", rd_hit, 2'b00);
    chk("t6_flush_drop_lit", drop_cnt, 2);
    rd(32'h3000);
    chk("t6_miss_lit", rd_hit, 2'b00);
    rd(32'h1080);
    for (int c = 0; c < 2; c++)
      step(32'h3000, 2'b11, 32'h3500 + 32'(8 * c), 32'h1, 32'h3504 + 32'(8 * c), 32'h2, 2'b00, 1'b0);
    step(32'h3500, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("t6_middrain_lit", q_count, 1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_hit", rd_hit, 0);
    chk("arst_target", rd_target, 0);
    chk("arst_qcount", q_count, 0);
    chk("arst_qfull", q_full, 0);
    chk("arst_drop", drop_cnt, 0);
    rst = 1'b0;
    rd(32'h3500);
    rd(32'h3500);
    chk("arst_after_lit", rd_hit, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
